frame_streamer: RTL and testbench
=================================

Name: frame_streamer

Overview:
- Raster pixel source: reads a stored WIDTH x HEIGHT 8-bit frame from a synchronous-read memory port and emits it as a pixel stream.
- Output is shaped for the 3x3 window / Sobel pipeline (pixel + valid), and adds ready backpressure, line/frame markers and optional blanking between lines.
- Sits between the frame buffer (BRAM) and the window generator input; started by a one-cycle start pulse, reports done.

Parameters:
- WIDTH, 8, pixels per line (>=2)
- HEIGHT, 8, lines per frame (>=1)
- LINE_GAP, 0, idle (pixel_valid low) cycles inserted after each line except the last
- ADDR_W, $clog2(WIDTH*HEIGHT), memory address width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- start  in  1  begin one frame; sampled only in IDLE
- mem_en  out  1  memory read enable
- mem_addr  out  ADDR_W  read address, raster order (line*WIDTH+col)
- mem_rdata  in  8  read data, valid exactly 1 cycle after the edge where mem_en/mem_addr were sampled
- pixel_out  out  8  pixel data
- pixel_valid  out  1  pixel_out valid
- pixel_ready  in  1  downstream accepts; transfer = pixel_valid & pixel_ready
- sol  out  1  qualifies pixel_out as column 0
- eol  out  1  qualifies pixel_out as column WIDTH-1
- sof  out  1  qualifies pixel_out as first pixel of frame
- eof  out  1  qualifies pixel_out as last pixel of frame
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after last transfer

Behaviour:
- Reset (rst=0 at an edge): all outputs 0; mem_addr=0; counters, skid buffer and FSM cleared; state IDLE. Mid-frame reset aborts immediately. No pixel is emitted after it and no done pulse is produced.
- FSM states:
  - IDLE: start=1 -> READ; busy=1 from the next edge.
  - READ: issue reads in raster order.
  - GAP: LINE_GAP cycles, no reads issued.
  - DRAIN: all reads issued; wait for in-flight data and buffered pixels to transfer.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Transitions:
  - READ -> GAP after issuing address col=WIDTH-1, if LINE_GAP>0 and not the last line.
  - GAP -> READ when the gap counter expires.
  - READ -> DRAIN after issuing the last address.
  - DRAIN -> DONE when the eof pixel transfers.
- start in any non-IDLE state is ignored.
- Read issue: mem_en=1 only if the 2-entry skid buffer will have room for the returning data. Room is counted as entries occupied + reads in flight <= 1 after this cycle's transfer. mem_addr increments by 1 per issued read and wraps to 0 at end of frame.
- Latency: with pixel_ready=1, start sampled at edge T -> mem_en=1, mem_addr=0 after T; pixel_valid=1 with pixel 0 after edge T+2.
- Throughput: with pixel_ready held high and LINE_GAP=0, one pixel per cycle, no bubbles. Frame completes in WIDTH*HEIGHT+2 cycles after start; done rises the cycle after the eof transfer.
- Backpressure: while pixel_valid=1 and pixel_ready=0, pixel_out, sol, eol, sof and eof hold stable. No data is lost or duplicated; the skid buffer absorbs the in-flight read.
- Markers travel with their pixel through the buffer; for WIDTH*HEIGHT pixels: sof=1 once, eof=1 once, sol=1 HEIGHT times, eol=1 HEIGHT times.
- HEIGHT=1: sof and sol coincide on the first pixel, eof and eol on the last.
- LINE_GAP: counted in cycles from the last read issue of a line. Gap cycles seen downstream are >= LINE_GAP when unstalled.
- Only one frame per start; a new start is accepted in IDLE only, the cycle after done.

Test Plan:
- WIDTH=4, HEIGHT=3, mem[i]=i+16, pixel_ready=1, start at T -> pixel_valid high T+2..T+13, data 16..27 consecutive. sof on 16, eol on 19/23/27, sol on 16/20/24, eof on 27, done pulse at T+14, busy low at T+14.
- Same frame, pixel_ready toggling 1,0,0,1 repeating -> exactly 12 transfers, values 16..27 in order, outputs stable during every stall, done after pixel 27 transfers.
- LINE_GAP=3, pixel_ready=1 -> pixel_valid low for exactly 3 cycles between 19->20 and 23->24, no gap after 27.
- start pulsed again mid-frame (e.g. at pixel 5) -> ignored; sequence unchanged; second start after done streams 16..27 again with mem_addr restarting at 0.
- rst=0 asserted at pixel 7 for one cycle -> next cycle all outputs 0, state IDLE, no done. Subsequent start streams full frame from 16.
- pixel_ready=0 from first valid for 10 cycles -> mem_en stops after 2 outstanding, pixel_out=16 held. On release, 16..27 stream without loss.

Source files
------------

// File: rtl/frame_streamer.sv
// Raster frame reader: streams a WIDTH x HEIGHT 8-bit frame from a 1-cycle-latency
// memory port as pixel/valid/ready with sol/eol/sof/eof markers and optional line gaps.
module frame_streamer #(
    parameter int WIDTH    = 8,
    parameter int HEIGHT   = 8,
    parameter int LINE_GAP = 0,
    parameter int ADDR_W   = $clog2(WIDTH * HEIGHT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        pixel_out,
    output logic              pixel_valid,
    input  logic              pixel_ready,
    output logic              sol,
    output logic              eol,
    output logic              sof,
    output logic              eof,
    output logic              busy,
    output logic              done
);

    localparam int COL_W  = $clog2(WIDTH);
    localparam int LINE_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int GAP_W  = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(WIDTH - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(HEIGHT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);

    // marker bit positions: {sof, eof, sol, eol}
    localparam int MK_SOF = 3;
    localparam int MK_EOF = 2;
    localparam int MK_SOL = 1;
    localparam int MK_EOL = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_GAP,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              infl_q, infl_d;
    logic [3:0]        infl_mark_q, infl_mark_d;
    logic [1:0]        count_q, count_d;
    logic [7:0]        buf_data_q [2];
    logic [7:0]        buf_data_d [2];
    logic [3:0]        buf_mark_q [2];
    logic [3:0]        buf_mark_d [2];

    logic       xfer;
    logic       issue;
    logic       last_col;
    logic       last_line;
    logic [2:0] pend;
    logic [1:0] cnt_pop;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        col_d       = col_q;
        line_d      = line_q;
        gap_d       = gap_q;
        buf_data_d  = buf_data_q;
        buf_mark_d  = buf_mark_q;

        xfer      = (count_q != 2'd0) && pixel_ready;
        last_col  = (col_q == COL_LAST);
        last_line = (line_q == LINE_LAST);

        // A read may issue only if its data is guaranteed a buffer slot on return.
        pend  = 3'(count_q) + 3'(infl_q) - 3'(xfer);
        issue = (state_q == S_READ) && (pend <= 3'd1);

        infl_d      = issue;
        infl_mark_d = {addr_q == '0, last_col && last_line, col_q == '0, last_col};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_READ;
                    addr_d  = '0;
                    col_d   = '0;
                    line_d  = '0;
                end
            end
            S_READ: begin
                if (issue) begin
                    if (last_col) begin
                        col_d = '0;
                        if (last_line) begin
                            addr_d  = '0;
                            line_d  = '0;
                            state_d = S_DRAIN;
                        end else begin
                            addr_d = addr_q + 1'b1;
                            line_d = line_q + 1'b1;
                            if (LINE_GAP > 0) begin
                                gap_d   = '0;
                                state_d = S_GAP;
                            end
                        end
                    end else begin
                        addr_d = addr_q + 1'b1;
                        col_d  = col_q + 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) state_d = S_READ;
                else                   gap_d   = gap_q + 1'b1;
            end
            S_DRAIN: begin
                if (xfer && buf_mark_q[0][MK_EOF]) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Two-entry FIFO: head in slot 0; returning read lands behind what remains.
        cnt_pop = count_q - 2'(xfer);
        if (xfer) begin
            buf_data_d[0] = buf_data_q[1];
            buf_mark_d[0] = buf_mark_q[1];
        end
        if (infl_q) begin
            buf_data_d[cnt_pop[0]] = mem_rdata;
            buf_mark_d[cnt_pop[0]] = infl_mark_q;
        end
        count_d = cnt_pop + 2'(infl_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            col_q         <= '0;
            line_q        <= '0;
            gap_q         <= '0;
            infl_q        <= 1'b0;
            infl_mark_q   <= '0;
            count_q       <= '0;
            buf_data_q[0] <= '0;
            buf_data_q[1] <= '0;
            buf_mark_q[0] <= '0;
            buf_mark_q[1] <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            col_q       <= col_d;
            line_q      <= line_d;
            gap_q       <= gap_d;
            infl_q      <= infl_d;
            infl_mark_q <= infl_mark_d;
            count_q     <= count_d;
            buf_data_q  <= buf_data_d;
            buf_mark_q  <= buf_mark_d;
        end
    end

    assign mem_en      = issue;
    assign mem_addr    = addr_q;
    assign pixel_valid = (count_q != 2'd0);
    assign pixel_out   = pixel_valid ? buf_data_q[0] : 8'd0;
    assign sof         = pixel_valid & buf_mark_q[0][MK_SOF];
    assign eof         = pixel_valid & buf_mark_q[0][MK_EOF];
    assign sol         = pixel_valid & buf_mark_q[0][MK_SOL];
    assign eol         = pixel_valid & buf_mark_q[0][MK_EOL];
    assign busy        = (state_q == S_READ) || (state_q == S_GAP) || (state_q == S_DRAIN);
    assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_frame_streamer.sv
// Scoreboard bench: two frame_streamer instances (LINE_GAP 0 and 3) share stimulus;
// a negedge monitor checks pixels, markers, timing, stalls and reset against a frame model.
module tb_frame_streamer;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int AW = 4;

    typedef struct packed {
        logic [7:0] d;
        logic       sof, eof, sol, eol;
    } px_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic rdy = 1'b1;
    logic [7:0] mem [N];

    logic [1:0]    mem_en, pv, sol, eol, sof, eof, busy, done;
    logic [AW-1:0] addr  [2];
    logic [7:0]    rdata [2];
    logic [7:0]    pout  [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        frame_streamer #(.WIDTH(W), .HEIGHT(H), .LINE_GAP(g * 3)) dut (
            .clk(clk), .rst(rst), .start(start),
            .mem_en(mem_en[g]), .mem_addr(addr[g]), .mem_rdata(rdata[g]),
            .pixel_out(pout[g]), .pixel_valid(pv[g]), .pixel_ready(rdy),
            .sol(sol[g]), .eol(eol[g]), .sof(sof[g]), .eof(eof[g]),
            .busy(busy[g]), .done(done[g])
        );
    end

    always @(posedge clk)
        for (int g = 0; g < 2; g++)
            if (mem_en[g]) rdata[g] <= mem[addr[g]];

    // ---------------- monitor / scoreboard ----------------
    typedef enum int {P_IDLE, P_RUN, P_DONE} ph_t;

    px_t  expq [2][$];
    ph_t  ph   [2] = '{P_IDLE, P_IDLE};
    int   acc  [2], iss [2], xf [2], gc [2];
    logic fr   [2], ing [2], stl [2];
    px_t  snap [2];
    int   cyc = 0, nchk = 0, nfail = 0;
    logic prev_rst = 1'b0;
    logic en_chk = 1'b0, tmo_req = 1'b0, fin = 1'b0, fin_ack = 1'b0;

    task automatic ck(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", nm, g, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (en_chk) begin
            for (int g = 0; g < 2; g++) begin
                px_t  got, e;
                logic x;
                got = {pout[g], sof[g], eof[g], sol[g], eol[g]};
                x   = pv[g] & rdy;

                if (!prev_rst)
                    ck("reset_outputs", g, {mem_en[g], pv[g], busy[g], done[g], got, addr[g]}, 0);
                ck("busy", g, busy[g], ph[g] == P_RUN);
                ck("done", g, done[g], ph[g] == P_DONE);
                if (stl[g] && prev_rst) ck("stall_hold", g, {pv[g], got}, {1'b1, snap[g]});

                if (x) begin
                    if (expq[g].size() == 0) begin
                        nchk++; nfail++;
                        $display("FAIL extra_pixel dut%0d: got %0h expected none (cycle %0d)", g, got, cyc);
                    end else begin
                        e = expq[g].pop_front();
                        ck("pixel", g, got, e);
                        // start sampled at edge acc+1; first pixel valid after edge acc+3
                        if (fr[g] && e.sof) ck("first_latency", g, cyc - acc[g], 3);
                    end
                    xf[g]++;
                end

                if (ing[g]) begin
                    if (pv[g]) begin
                        if (fr[g]) ck("line_gap", g, gc[g], g * 3);
                        ing[g] = 1'b0;
                    end else gc[g]++;
                end
                if (x && got.eol && !got.eof) begin ing[g] = 1'b1; gc[g] = 0; end

                if (mem_en[g]) begin
                    ck("read_room", g, (iss[g] - xf[g]) <= 1, 1);
                    ck("mem_addr", g, addr[g], iss[g] % N);
                    iss[g]++;
                end

                if (done[g] && fr[g]) ck("done_latency", g, cyc - acc[g], N + 3 + (H - 1) * g * 3);
                if (ph[g] == P_RUN && !rdy) fr[g] = 1'b0;
                stl[g]  = pv[g] & ~rdy;
                snap[g] = got;

                if (!rst) begin
                    ph[g] = P_IDLE;
                    expq[g].delete();
                    stl[g] = 1'b0;
                    ing[g] = 1'b0;
                end else begin
                    case (ph[g])
                        P_IDLE: if (start) begin
                            ph[g] = P_RUN; acc[g] = cyc; iss[g] = 0; xf[g] = 0;
                            fr[g] = 1'b1; ing[g] = 1'b0;
                            for (int k = 0; k < N; k++)
                                expq[g].push_back({mem[k], k == 0, k == N - 1, (k % W) == 0, (k % W) == W - 1});
                        end
                        P_RUN:  if (x && got.eof) ph[g] = P_DONE;
                        default: begin
                            ck("frame_complete", g, expq[g].size(), 0);
                            ph[g] = P_IDLE;
                        end
                    endcase
                end
            end
            if (tmo_req) begin
                nchk++; nfail++;
                $display("FAIL timeout: got busy still high expected idle (cycle %0d)", cyc);
            end
            if (fin && !fin_ack) begin
                for (int g = 0; g < 2; g++) begin
                    ck("queue_empty", g, expq[g].size(), 0);
                    ck("final_idle", g, {busy[g], pv[g], mem_en[g]}, 0);
                end
                fin_ack = 1'b1;
            end
        end
        prev_rst = rst;
    end

    // ---------------- stimulus ----------------
    int mode = 0, sc = 0, hold = 0;

    task automatic step();
        @(posedge clk);
        #1;
        sc++;
        case (mode)
            0: rdy = 1'b1;
            1: rdy = ((sc % 4) == 0) || ((sc % 4) == 3);
            2: rdy = 1'($urandom_range(0, 1));
            default: begin rdy = (hold > 0) ? 1'b0 : 1'b1; if (hold > 0) hold--; end
        endcase
    endtask

    task automatic go();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            step();
            if (busy == 2'b00 && done == 2'b00) return;
        end
        tmo_req = 1'b1;
        step();
        tmo_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) mem[i] = 8'(i + 16);
        repeat (2) step();
        en_chk = 1'b1;
        step();
        rst = 1'b1;
        step();

        mode = 0; go(); wait_idle();          // full rate
        mode = 1; go(); wait_idle();          // ready 1,0,0,1

        mode = 0; go();                       // start during a running frame
        repeat (6) step();
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 100 && !done[0]; i++) step();
        start = 1'b1; step();                 // in DONE: ignored
        step(); start = 1'b0;                 // IDLE: accepted
        wait_idle();

        go(); repeat (8) step();              // reset mid-frame
        rst = 1'b0; step(); rst = 1'b1;
        repeat (3) step();
        go(); wait_idle();

        mode = 3; hold = 12; go(); wait_idle(); // long initial stall

        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
            mode = (f == 4) ? 0 : 2;
            go(); wait_idle();
        end

        mode = 0;
        fin = 1'b1;
        for (int i = 0; i < 10 && !fin_ack; i++) step();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
